// File: rtl/dct_pkg.sv
// Shared constants and types for the serial row unloader.
package dct_pkg;
    localparam int WIDTH_DEF = 11;
    localparam int ROWLEN    = 8;
    localparam int IDX_W     = 3;

    typedef logic [IDX_W-1:0] idx_t;

    localparam idx_t IDX_LAST = idx_t'(ROWLEN - 1);
endpackage

// File: rtl/dct_bank8.sv
// Eight-entry register bank: whole-row parallel load, one indexed read port.
module dct_bank8
    import dct_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we_i,
    input  logic [ROWLEN-1:0][WIDTH-1:0]   wdata_i,
    input  logic [IDX_W-1:0]               raddr_i,
    output logic [WIDTH-1:0]               rdata_o,
    output logic [ROWLEN-1:0][WIDTH-1:0]   row_o
);
    logic [ROWLEN-1:0][WIDTH-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
    assign row_o   = mem_q;
endmodule

// File: rtl/dct_ser_8xn.sv
// Double-buffered parallel-to-serial row unloader: hold bank feeds active bank,
// active bank streams p0..p7 under the en advance strobe.
module dct_ser_8xn
    import dct_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [WIDTH-1:0] d4,
    input  logic [WIDTH-1:0] d5,
    input  logic [WIDTH-1:0] d6,
    input  logic [WIDTH-1:0] d7,
    input  logic             ld,
    output logic             ld_rdy,
    input  logic             en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic [IDX_W-1:0] ra,
    output logic             last
);
    logic hold_full_q, hold_full_d;
    logic ld_rdy_q;
    logic vld_q, vld_d;
    idx_t ra_q, ra_d;

    logic ld_acc, row_end, xfer;
    logic [ROWLEN-1:0][WIDTH-1:0] din_row, hold_row, act_row;
    logic [WIDTH-1:0] hold_rd, act_rd;
    logic unused_sig;

    assign din_row = {d7, d6, d5, d4, d3, d2, d1, d0};

    assign ld_acc  = ld && ld_rdy_q;
    assign row_end = vld_q && en && (ra_q == IDX_LAST);
    // Refill the active bank when it is idle or finishing its last element.
    assign xfer    = hold_full_q && (!vld_q || row_end);

    always_comb begin
        hold_full_d = hold_full_q;
        vld_d       = vld_q;
        ra_d        = ra_q;
        if (xfer) begin
            hold_full_d = 1'b0;
            vld_d       = 1'b1;
            ra_d        = '0;
        end else begin
            if (ld_acc) begin
                hold_full_d = 1'b1;
            end
            if (row_end) begin
                vld_d = 1'b0;
                ra_d  = '0;
            end else if (vld_q && en) begin
                ra_d = ra_q + idx_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_full_q <= 1'b0;
            ld_rdy_q    <= 1'b1;
            vld_q       <= 1'b0;
            ra_q        <= '0;
        end else begin
            hold_full_q <= hold_full_d;
            ld_rdy_q    <= !hold_full_d;
            vld_q       <= vld_d;
            ra_q        <= ra_d;
        end
    end

    dct_bank8 #(.WIDTH(WIDTH)) u_hold (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ld_acc),
        .wdata_i (din_row),
        .raddr_i (ra_q),
        .rdata_o (hold_rd),
        .row_o   (hold_row)
    );

    dct_bank8 #(.WIDTH(WIDTH)) u_act (
        .clk     (clk),
        .rst     (rst),
        .we_i    (xfer),
        .wdata_i (hold_row),
        .raddr_i (ra_q),
        .rdata_o (act_rd),
        .row_o   (act_row)
    );

    assign unused_sig = ^{hold_rd, act_row};

    assign ld_rdy   = ld_rdy_q;
    assign dout     = vld_q ? act_rd : '0;
    assign dout_vld = vld_q;
    assign ra       = ra_q;
    assign last     = vld_q && (ra_q == IDX_LAST);
endmodule

// File: tb/tb_dct_ser_8xn.sv
// Scoreboard bench for dct_ser_8xn: directed rows, monitor compares each streamed element.
module tb_dct_ser_8xn;
    localparam int W = 11;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic         ld, en;
    logic         ld_rdy, dout_vld, last;
    logic [W-1:0] dout;
    logic [2:0]   ra;

    typedef struct packed {
        logic [W-1:0] data;
        logic [2:0]   idx;
    } exp_t;

    exp_t         sbq[$];
    logic [W-1:0] row[8];
    int           n_tests = 0;
    int           n_fail  = 0;

    dct_ser_8xn #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
        .ld(ld), .ld_rdy(ld_rdy), .en(en),
        .dout(dout), .dout_vld(dout_vld), .ra(ra), .last(last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid element must match the queue head; it pops only when consumed.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (dout_vld) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got dout=%0h ra=%0d, expected no output", dout, ra);
                end else begin
                    check("dout", 32'(dout), 32'(sbq[0].data));
                    check("ra", 32'(ra), 32'(sbq[0].idx));
                    check("last", 32'(last), 32'(sbq[0].idx == 3'd7));
                    if (en) void'(sbq.pop_front());
                end
            end else begin
                check("idle_dout_zero", 32'(dout), 32'd0);
                check("idle_last_zero", 32'(last), 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_row(input int base);
        for (int i = 0; i < 8; i++) row[i] = W'(base + i);
    endtask

    task automatic load_row(input bit expect_accept);
        d0 = row[0]; d1 = row[1]; d2 = row[2]; d3 = row[3];
        d4 = row[4]; d5 = row[5]; d6 = row[6]; d7 = row[7];
        ld = 1'b1;
        tick();
        ld = 1'b0;
        if (expect_accept) begin
            for (int i = 0; i < 8; i++) sbq.push_back('{data: row[i], idx: 3'(i)});
        end
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        while ((sbq.size() != 0 || dout_vld) && cyc < 200) begin
            tick();
            cyc++;
        end
        check({name, "_drained"}, 32'(sbq.size()), 32'd0);
        check({name, "_vld_low"}, 32'(dout_vld), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        set_row(77);
        d0 = row[0]; d1 = row[1]; d2 = row[2]; d3 = row[3];
        d4 = row[4]; d5 = row[5]; d6 = row[6]; d7 = row[7];
        ld = 1'b1;
        tick();
        tick();
        ld  = 1'b0;
        rst = 1'b0;
        check("rst_ld_rdy", 32'(ld_rdy), 32'd1);
        check("rst_vld", 32'(dout_vld), 32'd0);
        check("rst_ra", 32'(ra), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        tick();
        check("rst_ld_overridden", 32'(dout_vld), 32'd0);

        // Single row 1..8 with en held high
        set_row(1);
        load_row(1'b1);
        check("single_latency_vld", 32'(dout_vld), 32'd0);
        check("single_hold_full", 32'(ld_rdy), 32'd0);
        tick();
        check("single_first_vld", 32'(dout_vld), 32'd1);
        check("single_first_dout", 32'(dout), 32'd1);
        check("single_ld_rdy_back", 32'(ld_rdy), 32'd1);
        drain("single");

        // Back-to-back rows 10..17 then 20..27, no gap
        set_row(10);
        load_row(1'b1);
        tick();
        set_row(20);
        load_row(1'b1);
        for (int i = 0; i < 14; i++) begin
            tick();
            check("b2b_no_gap", 32'(dout_vld), 32'd1);
        end
        tick();
        check("b2b_end_vld", 32'(dout_vld), 32'd0);
        drain("b2b");

        // Stall pattern 1,0,0,1 on en
        en = 1'b0;
        set_row(1);
        load_row(1'b1);
        for (int c = 0; c < 80 && (sbq.size() != 0 || dout_vld); c++) begin
            en = ((c % 4) == 0 || (c % 4) == 3);
            tick();
        end
        en = 1'b1;
        drain("stall");

        // Full hold: act busy, hold full, ld of 99 must be ignored
        en = 1'b0;
        set_row(40);
        load_row(1'b1);
        tick();
        set_row(50);
        load_row(1'b1);
        check("full_ld_rdy_low", 32'(ld_rdy), 32'd0);
        for (int i = 0; i < 8; i++) row[i] = W'(99);
        load_row(1'b0);
        check("full_ld_rdy_still_low", 32'(ld_rdy), 32'd0);
        check("full_act_held", 32'(dout), 32'd40);
        en = 1'b1;
        drain("full");
        check("full_ld_rdy_after", 32'(ld_rdy), 32'd1);

        // Mid-row reset at ra==4
        set_row(60);
        load_row(1'b1);
        for (int c = 0; c < 20; c++) begin
            if (dout_vld && ra == 3'd4) break;
            tick();
        end
        check("midrst_reached_ra4", 32'(ra), 32'd4);
        rst = 1'b1;
        sbq.delete();
        tick();
        rst = 1'b0;
        check("midrst_vld", 32'(dout_vld), 32'd0);
        check("midrst_ra", 32'(ra), 32'd0);
        check("midrst_ld_rdy", 32'(ld_rdy), 32'd1);
        check("midrst_dout", 32'(dout), 32'd0);
        set_row(30);
        load_row(1'b1);
        tick();
        check("midrst_restart_p0", 32'(dout), 32'd30);
        drain("midrst");

        // Width extremes
        set_row(1);
        row[0] = 11'h7FF;
        row[7] = 11'h400;
        load_row(1'b1);
        tick();
        check("width_p0", 32'(dout), 32'h7FF);
        drain("width");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dct_ser_8xn.md
DCT_SER_8XN -- requirements
Module: dct_ser_8xn

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 11, sample width in bits.
REQ-002 Port clk SHALL be: clk, input, 1, sole clock, all state updates on posedge.
REQ-003 Port rst SHALL be: rst, input, 1, synchronous active-high reset.
REQ-004 Ports d0..d7 SHALL be: d0..d7, input, WIDTH each, parallel row elements p0..p7.
REQ-005 Port ld SHALL be: ld, input, 1, row-load request.
REQ-006 Port ld_rdy SHALL be: ld_rdy, output, 1, registered; high means the holding bank is empty.
REQ-007 Port en SHALL be: en, input, 1, advance enable for serial output.
REQ-008 Port dout SHALL be: dout, output, WIDTH, current serial element.
REQ-009 Port dout_vld SHALL be: dout_vld, output, 1, dout valid.
REQ-010 Port ra SHALL be: ra, output, 3, index (0..7) of the element on dout.
REQ-011 Port last SHALL be: last, output, 1, high when dout_vld and ra==7.

Function
REQ-012 Block SHALL be a double-buffered parallel-to-serial row unloader: an 8-entry holding bank (hold) and an 8-entry active bank (act).
REQ-013 Load accept SHALL occur when ld && ld_rdy at a posedge: hold <= d0..d7, hold_full <= 1.
REQ-014 ld while ld_rdy==0 SHALL be ignored; hold is unchanged.
REQ-015 ld_rdy SHALL equal !hold_full, driven from a register with no combinational path from ld or en.
REQ-016 Transfer SHALL occur at a posedge when hold_full && (!dout_vld || (en && ra==7)): act <= hold, hold_full <= 0, ra <= 0, dout_vld <= 1.
REQ-017 Transfer and load SHALL NOT coincide, because ld_rdy==0 whenever hold_full==1.
REQ-018 Latency SHALL be: ld accepted at edge k -> dout_vld=1 with ra=0 from edge k+1, provided act is idle.
REQ-019 dout SHALL equal act[ra] combinationally from registered state, and SHALL be 0 when dout_vld==0.
REQ-020 Advance: when dout_vld && en && ra!=7, ra SHALL increment by 1.
REQ-021 When dout_vld && !en, ra, act and dout_vld SHALL hold.
REQ-022 Row end: when dout_vld && en && ra==7 with !hold_full, dout_vld <= 0 and ra <= 0; with hold_full, REQ-016 applies and the next row continues with no bubble cycle.
REQ-023 en while dout_vld==0 SHALL be ignored.
REQ-024 Element order SHALL be p0 first, p7 last, matching the write order of the row collector this block pairs with.
REQ-025 No arithmetic SHALL be performed on data; samples pass through bit-exact at WIDTH bits.

Reset
REQ-026 On rst=1 at a posedge: hold_full=0, ld_rdy=1, dout_vld=0, ra=0, last=0, dout=0; hold and act contents cleared to 0.
REQ-027 Reset SHALL override ld and en in the same cycle; a row in flight is discarded and no partial output follows reset.

Structure
REQ-028 Package dct_pkg SHALL hold the WIDTH default (11) and the row-length constant ROWLEN=8 with its index width 3.
REQ-029 One sub-module, dct_bank8 (8 x WIDTH register bank with parallel load and indexed read), SHALL be instantiated twice, once for hold and once for act.
REQ-030 Control (hold_full, dout_vld, ra) SHALL live in dct_ser_8xn only.

Verification
REQ-031 Single row: reset, ld=1 with d0..d7=1..8 for one cycle, en=1 continuously -> dout=1..8 on 8 consecutive cycles starting one cycle after load, last only on the 8 (ra=7) cycle, then dout_vld=0.
REQ-032 Back-to-back: load row A=10..17, then load row B=20..27 while A streams, en=1 -> 16 consecutive valid outputs 10..17,20..27 with no gap.
REQ-033 Stall: en toggles 1,0,0,1... during row 1..8 -> each value is held while en=0, ra does not skip, and the full order 1..8 is preserved.
REQ-034 Full hold: hold_full=1 and act busy, ld pulsed with d=99 -> ld_rdy=0, the load is ignored, and no 99 appears on dout.
REQ-035 Mid-row reset: rst asserted while ra=4 -> next cycle dout_vld=0, ra=0, ld_rdy=1, dout=0; a subsequent load streams from p0.
REQ-036 Width: WIDTH=11, d0=11'h7FF, d7=11'h400 -> dout bit-exact 11'h7FF and 11'h400.
